freelist_ctrl: RTL and testbench

FREELIST_CTRL -- requirements
Module: freelist_ctrl

---
 rtl/freelist_ctrl_pkg.sv | 26 ++
 rtl/freelist_free_compact.sv | 44 ++++
 rtl/freelist_ctrl.sv | 134 +++++++++++++
 tb/tb_freelist_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/freelist_ctrl_pkg.sv
// Shared core configuration for the rename free list: sizes, lane count and
// small bit-counting helpers used by the controller and its compaction stage.
package freelist_ctrl_pkg;

  localparam int CORE_FL_DEPTH   = 16;
  localparam int CORE_FL_INDEX   = 4;
  localparam int CORE_PHYS_WIDTH = 8;
  localparam int CORE_SIZE_RMT   = 32;
  localparam int NUM_LANES       = 4;
  localparam int LANE_CNT_W      = 3;

  function automatic logic [LANE_CNT_W-1:0] lane_popcount(input logic [NUM_LANES-1:0] v);
    logic [LANE_CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      acc = acc + LANE_CNT_W'(v[i]);
    end
    return acc;
  endfunction

  // Rename lanes must request from lane 0 upward with no holes.
  function automatic logic lane_contiguous(input logic [NUM_LANES-1:0] v);
    return ((v & (v + NUM_LANES'(1))) == '0);
  endfunction

endpackage

// File: rtl/freelist_free_compact.sv
// Packs the set bits of the retire free mask onto consecutive write ports:
// the k-th valid lane in ascending order lands on port k.
module freelist_free_compact
  import freelist_ctrl_pkg::*;
#(
  parameter int PHYS_WIDTH = CORE_PHYS_WIDTH
) (
  input  logic [NUM_LANES-1:0]                 free_valid,
  input  logic [NUM_LANES-1:0][PHYS_WIDTH-1:0] free_reg,
  output logic [NUM_LANES-1:0]                 port_valid,
  output logic [NUM_LANES-1:0][PHYS_WIDTH-1:0] port_data,
  output logic [LANE_CNT_W-1:0]                nfree
);

  logic [NUM_LANES-1:0][LANE_CNT_W-1:0] rank;

  always_comb begin
    logic [LANE_CNT_W-1:0] acc;
    acc = '0;
    rank = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      rank[l] = acc;
      acc = acc + LANE_CNT_W'(free_valid[l]);
    end
    nfree = acc;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_port
      always_comb begin
        port_valid[gi] = 1'b0;
        port_data[gi]  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
          if (free_valid[l] && (rank[l] == LANE_CNT_W'(gi))) begin
            port_valid[gi] = 1'b1;
            port_data[gi]  = free_reg[l];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/freelist_ctrl.sv
// Circular free-list controller for a 4-wide rename stage: all-or-nothing
// allocation from head, compacted frees appended at tail, sticky error flag.
module freelist_ctrl
  import freelist_ctrl_pkg::*;
#(
  parameter int FL_DEPTH   = CORE_FL_DEPTH,
  parameter int FL_INDEX   = CORE_FL_INDEX,
  parameter int PHYS_WIDTH = CORE_PHYS_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_LANES-1:0]  alloc_req_i,
  output logic                  alloc_grant_o,
  output logic                  stall_o,
  output logic [PHYS_WIDTH-1:0] alloc_reg0_o,
  output logic [PHYS_WIDTH-1:0] alloc_reg1_o,
  output logic [PHYS_WIDTH-1:0] alloc_reg2_o,
  output logic [PHYS_WIDTH-1:0] alloc_reg3_o,
  input  logic [NUM_LANES-1:0]  free_valid_i,
  input  logic [PHYS_WIDTH-1:0] free_reg0_i,
  input  logic [PHYS_WIDTH-1:0] free_reg1_i,
  input  logic [PHYS_WIDTH-1:0] free_reg2_i,
  input  logic [PHYS_WIDTH-1:0] free_reg3_i,
  output logic [FL_INDEX-1:0]   rd_addr0_o,
  output logic [FL_INDEX-1:0]   rd_addr1_o,
  output logic [FL_INDEX-1:0]   rd_addr2_o,
  output logic [FL_INDEX-1:0]   rd_addr3_o,
  input  logic [PHYS_WIDTH-1:0] rd_data0_i,
  input  logic [PHYS_WIDTH-1:0] rd_data1_i,
  input  logic [PHYS_WIDTH-1:0] rd_data2_i,
  input  logic [PHYS_WIDTH-1:0] rd_data3_i,
  output logic [FL_INDEX-1:0]   wr_addr0_o,
  output logic [FL_INDEX-1:0]   wr_addr1_o,
  output logic [FL_INDEX-1:0]   wr_addr2_o,
  output logic [FL_INDEX-1:0]   wr_addr3_o,
  output logic                  we0_o,
  output logic                  we1_o,
  output logic                  we2_o,
  output logic                  we3_o,
  output logic [PHYS_WIDTH-1:0] wr_data0_o,
  output logic [PHYS_WIDTH-1:0] wr_data1_o,
  output logic [PHYS_WIDTH-1:0] wr_data2_o,
  output logic [PHYS_WIDTH-1:0] wr_data3_o,
  output logic [FL_INDEX:0]     free_cnt_o,
  output logic                  overflow_o
);

  logic [FL_INDEX-1:0]   head_reg, head_next;
  logic [FL_INDEX:0]     count_reg, count_next;
  logic                  overflow_reg, overflow_next;
  logic [FL_INDEX-1:0]   tail;
  logic [LANE_CNT_W-1:0] nalloc, nfree, granted_n;
  logic                  req_ok, grant_raw, over_now;
  logic [FL_INDEX+1:0]   count_sum;

  logic [NUM_LANES-1:0][PHYS_WIDTH-1:0] free_regs, port_data;
  logic [NUM_LANES-1:0][FL_INDEX-1:0]   rd_addr, wr_addr;
  logic [NUM_LANES-1:0]                 port_valid, we;

  assign free_regs = {free_reg3_i, free_reg2_i, free_reg1_i, free_reg0_i};

  freelist_free_compact #(.PHYS_WIDTH(PHYS_WIDTH)) u_compact (
    .free_valid (free_valid_i),
    .free_reg   (free_regs),
    .port_valid (port_valid),
    .port_data  (port_data),
    .nfree      (nfree)
  );

  // Count of FL_DEPTH truncates to 0 here, so tail = head when the list is full.
  assign tail      = head_reg + count_reg[FL_INDEX-1:0];
  assign nalloc    = lane_popcount(alloc_req_i);
  assign req_ok    = lane_contiguous(alloc_req_i);
  assign grant_raw = req_ok && (nalloc != '0) && (count_reg >= (FL_INDEX+1)'(nalloc));
  assign granted_n = grant_raw ? nalloc : '0;

  // Freed tags only join count at the next edge, so grant never sees them early.
  assign count_sum = {1'b0, count_reg} + (FL_INDEX+2)'(nfree) - (FL_INDEX+2)'(granted_n);
  assign over_now  = (count_sum > (FL_INDEX+2)'(FL_DEPTH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign rd_addr[gi] = head_reg + FL_INDEX'(gi);
      assign wr_addr[gi] = tail + FL_INDEX'(gi);
      assign we[gi]      = reset_n && port_valid[gi] && !over_now;
    end
  endgenerate

  assign alloc_grant_o = reset_n && grant_raw;
  assign stall_o       = reset_n && (alloc_req_i != '0) && !grant_raw;

  always_comb begin
    head_next     = grant_raw ? head_reg + FL_INDEX'(nalloc) : head_reg;
    count_next    = over_now ? (FL_INDEX+1)'(FL_DEPTH) : count_sum[FL_INDEX:0];
    overflow_next = overflow_reg || over_now || !req_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_reg     <= '0;
      count_reg    <= (FL_INDEX+1)'(FL_DEPTH);
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign rd_addr0_o   = rd_addr[0];
  assign rd_addr1_o   = rd_addr[1];
  assign rd_addr2_o   = rd_addr[2];
  assign rd_addr3_o   = rd_addr[3];
  assign alloc_reg0_o = rd_data0_i;
  assign alloc_reg1_o = rd_data1_i;
  assign alloc_reg2_o = rd_data2_i;
  assign alloc_reg3_o = rd_data3_i;
  assign wr_addr0_o   = wr_addr[0];
  assign wr_addr1_o   = wr_addr[1];
  assign wr_addr2_o   = wr_addr[2];
  assign wr_addr3_o   = wr_addr[3];
  assign we0_o        = we[0];
  assign we1_o        = we[1];
  assign we2_o        = we[2];
  assign we3_o        = we[3];
  assign wr_data0_o   = port_data[0];
  assign wr_data1_o   = port_data[1];
  assign wr_data2_o   = port_data[2];
  assign wr_data3_o   = port_data[3];
  assign free_cnt_o   = count_reg;
  assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl with a 16-entry 4R4W SRAM model whose
// reset contents are entry i = i + 32.
module tb_freelist_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] alloc_req, free_valid;
  logic       grant, stall, overflow;
  logic [7:0] alloc_reg0, alloc_reg1, alloc_reg2, alloc_reg3;
  logic [7:0] free_reg0, free_reg1, free_reg2, free_reg3;
  logic [3:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [7:0] rd_data0, rd_data1, rd_data2, rd_data3;
  logic [3:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
  logic       we0, we1, we2, we3;
  logic [7:0] wr_data0, wr_data1, wr_data2, wr_data3;
  logic [4:0] free_cnt;
  logic [7:0] mem [16];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) mem[i] = 8'(i + 32);

  always @(posedge clk) begin
    if (we0) mem[wr_addr0] <= wr_data0;
    if (we1) mem[wr_addr1] <= wr_data1;
    if (we2) mem[wr_addr2] <= wr_data2;
    if (we3) mem[wr_addr3] <= wr_data3;
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];
  assign rd_data3 = mem[rd_addr3];

  freelist_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_req_i(alloc_req), .alloc_grant_o(grant), .stall_o(stall),
    .alloc_reg0_o(alloc_reg0), .alloc_reg1_o(alloc_reg1),
    .alloc_reg2_o(alloc_reg2), .alloc_reg3_o(alloc_reg3),
    .free_valid_i(free_valid),
    .free_reg0_i(free_reg0), .free_reg1_i(free_reg1),
    .free_reg2_i(free_reg2), .free_reg3_i(free_reg3),
    .rd_addr0_o(rd_addr0), .rd_addr1_o(rd_addr1),
    .rd_addr2_o(rd_addr2), .rd_addr3_o(rd_addr3),
    .rd_data0_i(rd_data0), .rd_data1_i(rd_data1),
    .rd_data2_i(rd_data2), .rd_data3_i(rd_data3),
    .wr_addr0_o(wr_addr0), .wr_addr1_o(wr_addr1),
    .wr_addr2_o(wr_addr2), .wr_addr3_o(wr_addr3),
    .we0_o(we0), .we1_o(we1), .we2_o(we2), .we3_o(we3),
    .wr_data0_o(wr_data0), .wr_data1_o(wr_data1),
    .wr_data2_o(wr_data2), .wr_data3_o(wr_data3),
    .free_cnt_o(free_cnt), .overflow_o(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; alloc_req = '0; free_valid = '0;
    free_reg0 = '0; free_reg1 = '0; free_reg2 = '0; free_reg3 = '0;
    repeat (2) @(posedge clk);
    #1;
    alloc_req = 4'hF; free_valid = 4'hF; #1;
    check("rst_grant", grant, 0);
    check("rst_stall", stall, 0);
    check("rst_we0", we0, 0);
    alloc_req = '0; free_valid = '0; reset_n = 1'b1; #1;
    check("rst_cnt", free_cnt, 16);
    check("rst_ovf", overflow, 0);
    check("rst_rd0", rd_addr0, 0);

    // first 4-wide allocation
    alloc_req = 4'hF; #1;
    check("a1_grant", grant, 1);
    check("a1_stall", stall, 0);
    check("a1_tag0", alloc_reg0, 32);
    check("a1_tag1", alloc_reg1, 33);
    check("a1_tag2", alloc_reg2, 34);
    check("a1_tag3", alloc_reg3, 35);
    tick(); alloc_req = '0; #1;
    check("a1_cnt", free_cnt, 12);
    check("a1_rd0", rd_addr0, 4);

    // drain to empty, then a single-lane request must stall
    for (int i = 0; i < 3; i++) begin
      alloc_req = 4'hF; #1;
      check("drain_grant", grant, 1);
      tick();
    end
    alloc_req = 4'h1; #1;
    check("empty_cnt", free_cnt, 0);
    check("empty_stall", stall, 1);
    check("empty_grant", grant, 0);
    tick(); alloc_req = '0; #1;
    check("empty_head", rd_addr0, 0);
    check("empty_cnt2", free_cnt, 0);

    // compacted free while empty; same-cycle alloc stalls
    free_valid = 4'b1010; free_reg1 = 8'd40; free_reg3 = 8'd41; alloc_req = 4'h1; #1;
    check("fr_we0", we0, 1);
    check("fr_wa0", wr_addr0, 0);
    check("fr_wd0", wr_data0, 40);
    check("fr_we1", we1, 1);
    check("fr_wa1", wr_addr1, 1);
    check("fr_wd1", wr_data1, 41);
    check("fr_we2", we2, 0);
    check("fr_we3", we3, 0);
    check("fr_stall", stall, 1);
    check("fr_grant", grant, 0);
    tick(); free_valid = '0; #1;
    check("fr_grant2", grant, 1);
    check("fr_tag", alloc_reg0, 40);
    tick(); alloc_req = '0; #1;
    check("fr_cnt", free_cnt, 1);
    check("fr_rd0", rd_addr0, 1);

    // walk head to 14 with full list via simultaneous alloc and free
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    free_reg0 = 8'd50; free_reg1 = 8'd51; free_reg2 = 8'd52; free_reg3 = 8'd53;
    for (int i = 0; i < 3; i++) begin
      alloc_req = 4'hF; free_valid = 4'hF; #1;
      check("sim_wa0", wr_addr0, 32'(4 * i));
      check("sim_grant", grant, 1);
      tick();
    end
    alloc_req = 4'h3; free_valid = 4'h3; tick();
    alloc_req = 4'hF; free_valid = '0; #1;
    check("wrap_cnt", free_cnt, 16);
    check("wrap_rd0", rd_addr0, 14);
    check("wrap_rd1", rd_addr1, 15);
    check("wrap_rd2", rd_addr2, 0);
    check("wrap_rd3", rd_addr3, 1);
    check("wrap_grant", grant, 1);
    tick(); alloc_req = '0; #1;
    check("wrap_head", rd_addr0, 2);
    check("wrap_cnt2", free_cnt, 12);

    // refill to 16 with wrapping tail, then overflow
    free_valid = 4'hF; #1;
    check("refill_wa0", wr_addr0, 14);
    check("refill_wa2", wr_addr2, 0);
    check("refill_we3", we3, 1);
    tick(); free_valid = 4'h1; #1;
    check("ovf_cnt_pre", free_cnt, 16);
    check("ovf_we0", we0, 0);
    tick(); free_valid = '0; #1;
    check("ovf_flag", overflow, 1);
    check("ovf_cnt", free_cnt, 16);
    reset_n = 1'b0; tick();
    check("ovf_clear", overflow, 0);
    reset_n = 1'b1;

    // non-contiguous request
    alloc_req = 4'b0101; #1;
    check("nc_stall", stall, 1);
    check("nc_grant", grant, 0);
    tick(); alloc_req = '0; #1;
    check("nc_ovf", overflow, 1);
    check("nc_cnt", free_cnt, 16);
    check("nc_head", rd_addr0, 0);
    reset_n = 1'b0; tick(); reset_n = 1'b1;

    // reset asserted mid-stream
    alloc_req = 4'hF; tick();
    free_valid = 4'hF; reset_n = 1'b0; #1;
    check("mid_grant", grant, 0);
    check("mid_stall", stall, 0);
    check("mid_we0", we0, 0);
    check("mid_we3", we3, 0);
    tick(); reset_n = 1'b1; alloc_req = '0; free_valid = '0; #1;
    check("mid_head", rd_addr0, 0);
    check("mid_cnt", free_cnt, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
